// File: rtl/puf_dump_ctrl_if.sv
// puf_dump_ctrl_if: host UART and PUF RAM signals of the readout controller
interface puf_dump_ctrl_if #(
  parameter int RAM_DW = 16,
  parameter int RAM_AW = 13
);
  logic              uart_rx_ready;
  logic [7:0]        uart_rx_data;
  logic              uart_tx_ready;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_enable;
  logic [RAM_AW-1:0] ram_raddr;
  logic [RAM_DW-1:0] ram_rdata;
  logic              busy;
  logic              done;
  modport master (
    input  uart_rx_ready, uart_rx_data, uart_tx_ready, ram_rdata,
    output uart_tx_data, uart_tx_enable, ram_raddr, busy, done
  );
  modport slave (
    output uart_rx_ready, uart_rx_data, uart_tx_ready, ram_rdata,
    input  uart_tx_data, uart_tx_enable, ram_raddr, busy, done
  );
endinterface

// File: rtl/puf_dump_ctrl.sv
// puf_dump_ctrl: SRAM-PUF readout controller streaming full or partial RAM byte dumps to a UART
module puf_dump_ctrl #(
  parameter int         RAM_DW     = 16,
  parameter int         RAM_AW     = 13,
  parameter logic [7:0] CMD_FULL   = 8'h73,
  parameter logic [7:0] CMD_PART   = 8'h70,
  parameter bit         APPEND_XOR = 1'b1
) (
  input logic clk,
  input logic rst,
  puf_dump_ctrl_if.master bus
);
  localparam int LB = $clog2(RAM_DW / 8);
  localparam int BAW = RAM_AW + LB;
  localparam logic [16:0] NBYTES = 17'd1 << BAW;
  typedef enum logic [3:0] {INIT, IDLE, ARGS, MEMWAIT, LOAD, SEND, WAITTX, NEXT, CSUM} state_t;
  state_t state;
  logic [BAW-1:0] idx, idx_nx, lane;
  logic [16:0] cnt;
  logic [15:0] cnt_arg;
  logic [7:0] xsum, cur;
  logic [23:0] args;
  logic [1:0] argn;
  logic skip, last;
  always_comb begin
    idx_nx = idx + BAW'(1);
    lane = idx & BAW'(RAM_DW / 8 - 1);
    cur = 8'(bus.ram_rdata >> {lane, 3'b000});
    cnt_arg = {args[7:0], bus.uart_rx_data};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      bus.uart_tx_enable <= 1'b0;
      bus.uart_tx_data <= 8'h00;
      bus.ram_raddr <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      idx <= '0;
      cnt <= '0;
      xsum <= 8'h00;
      args <= '0;
      argn <= '0;
      skip <= 1'b0;
      last <= 1'b0;
    end else begin
      bus.uart_tx_enable <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        INIT: begin
          bus.uart_tx_enable <= 1'b1;
          state <= IDLE;
        end
        IDLE:
          if (bus.uart_rx_ready && (bus.uart_rx_data == CMD_FULL || bus.uart_rx_data == CMD_PART)) begin
            xsum <= 8'h00;
            bus.busy <= 1'b1;
            last <= 1'b0;
            argn <= '0;
            idx <= '0;
            cnt <= NBYTES;
            bus.ram_raddr <= '0;
            state <= bus.uart_rx_data == CMD_FULL ? MEMWAIT : ARGS;
          end
        ARGS:
          if (bus.uart_rx_ready) begin
            argn <= argn + 2'd1;
            args <= {args[15:0], bus.uart_rx_data};
            if (argn == 2'd3) begin
              idx <= BAW'(args[23:8]);
              cnt <= {1'b0, cnt_arg};
              bus.ram_raddr <= RAM_AW'(args[23:8] >> LB);
              if (cnt_arg != 16'd0) state <= MEMWAIT;
              else begin
                state <= APPEND_XOR ? CSUM : IDLE;
                bus.busy <= APPEND_XOR;
                bus.done <= !APPEND_XOR;
              end
            end
          end
        MEMWAIT: state <= LOAD;
        LOAD:
          if (bus.uart_tx_ready) begin
            bus.uart_tx_data <= cur;
            xsum <= xsum ^ cur;
            bus.uart_tx_enable <= 1'b1;
            state <= SEND;
          end
        SEND: begin
          skip <= 1'b1;
          state <= WAITTX;
        end
        WAITTX: begin
          skip <= 1'b0;
          if (!skip && bus.uart_tx_ready) begin
            state <= last ? IDLE : NEXT;
            bus.busy <= !last;
            bus.done <= last;
          end
        end
        NEXT: begin
          cnt <= cnt - 17'd1;
          if (cnt == 17'd1) begin
            state <= APPEND_XOR ? CSUM : IDLE;
            bus.busy <= APPEND_XOR;
            bus.done <= !APPEND_XOR;
          end else begin
            idx <= idx_nx;
            bus.ram_raddr <= RAM_AW'(idx_nx >> LB);
            state <= MEMWAIT;
          end
        end
        CSUM:
          if (bus.uart_tx_ready) begin
            bus.uart_tx_data <= xsum;
            bus.uart_tx_enable <= 1'b1;
            last <= 1'b1;
            state <= SEND;
          end
        default: state <= INIT;
      endcase
    end
endmodule

// File: tb/tb_puf_dump_ctrl.sv
// tb_puf_dump_ctrl: directed checks of dumps, wrap, checksum, dropped commands and reset on a 64-byte RAM
module tb_puf_dump_ctrl;
  localparam int DW = 16, AW = 5, NB = 64;
  logic clk = 1'b0, rst = 1'b1, tx_rdy = 1'b1;
  always #5 clk = ~clk;
  puf_dump_ctrl_if #(.RAM_DW(DW), .RAM_AW(AW)) bus();
  puf_dump_ctrl #(.RAM_DW(DW), .RAM_AW(AW), .CMD_FULL(8'h73), .CMD_PART(8'h70), .APPEND_XOR(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  assign bus.uart_tx_ready = tx_rdy;
  int n_vec = 0, n_bad = 0, viol_stab = 0, viol_en = 0, done_cnt = 0, busy_cyc = 0, hold = 0, h = 0, maxhold = 20;
  logic [7:0] held = 8'h00;
  logic [7:0] cap[$];
  always @(posedge clk) bus.ram_rdata <= {8'(bus.ram_raddr) ^ 8'hA5, 8'(bus.ram_raddr)};
  always @(posedge clk)
    if (rst) begin
      hold <= 0;
      tx_rdy <= 1'b1;
    end else if (bus.uart_tx_enable) begin
      if (!tx_rdy) viol_en++;
      cap.push_back(bus.uart_tx_data);
      held <= bus.uart_tx_data;
      h = $urandom_range(0, maxhold);
      hold <= h;
      tx_rdy <= h == 0;
    end else if (hold > 0) begin
      hold <= hold - 1;
      tx_rdy <= hold == 1;
    end
  always @(negedge clk) if (!rst && !tx_rdy && bus.uart_tx_data !== held) viol_stab++;
  always @(posedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.busy) busy_cyc++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] cap_at(input int i);
    return (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD;
  endfunction
  function automatic logic [7:0] mb(input int a);
    int k;
    k = (a % NB) / 2;
    return (a % 2 == 1) ? 8'(k) ^ 8'hA5 : 8'(k);
  endfunction
  task automatic rx(input logic [7:0] b);
    @(negedge clk);
    bus.uart_rx_data = b;
    bus.uart_rx_ready = 1'b1;
    @(negedge clk);
    bus.uart_rx_ready = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, t < 20000, 1);
  endtask
  task automatic wait_bytes(input string tag, input int n);
    int t = 0;
    while (cap.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, t < 5000, 1);
  endtask
  task automatic chk_dump(input string tag, input int start, input int n);
    int bad = 0;
    logic [7:0] x = 8'h00;
    chk({tag, "_len"}, cap.size(), n + 1);
    for (int i = 0; i < n; i++) begin
      if (cap_at(i) !== 32'(mb(start + i))) bad++;
      x ^= mb(start + i);
    end
    chk({tag, "_data"}, bad, 0);
    chk({tag, "_csum"}, cap_at(n), 32'(x));
    cap.delete();
  endtask
  initial begin
    int d, b0;
    bus.uart_rx_ready = 1'b0;
    bus.uart_rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.uart_tx_enable, 0);
    chk("rst_data", bus.uart_tx_data, 0);
    chk("rst_raddr", bus.ram_raddr, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("dummy_n", cap.size(), 1);
    chk("dummy_v", cap_at(0), 0);
    chk("idle_busy", bus.busy, 0);
    cap.delete();
    d = done_cnt;
    rx(8'h73);
    wait_done("full_to", d);
    chk("full_done", done_cnt - d, 1);
    chk("full_busy", bus.busy, 0);
    chk("full_b0", cap_at(0), 8'h00);
    chk("full_b1", cap_at(1), 8'hA5);
    chk("full_b63", cap_at(63), 8'hBA);
    chk("full_x", cap_at(64), 8'h00);
    chk_dump("full", 0, NB);
    d = done_cnt;
    rx(8'h70); rx(8'h3F); rx(8'hFE); rx(8'h00); rx(8'h04);
    wait_done("wrap_to", d);
    chk("wrap_b0", cap_at(0), 8'h1F);
    chk("wrap_b1", cap_at(1), 8'hBA);
    chk("wrap_b2", cap_at(2), 8'h00);
    chk("wrap_b3", cap_at(3), 8'hA5);
    chk("wrap_x", cap_at(4), 8'h00);
    chk("wrap_n", cap.size(), 5);
    cap.delete();
    maxhold = 0;
    repeat (25) @(negedge clk);
    d = done_cnt;
    rx(8'h70); rx(8'h00); rx(8'h03); rx(8'h00);
    b0 = busy_cyc;
    rx(8'h00);
    wait_done("zero_to", d);
    repeat (2) @(negedge clk);
    chk("zero_n", cap.size(), 1);
    chk("zero_x", cap_at(0), 8'h00);
    chk("zero_busy", busy_cyc - b0 < 10, 1);
    chk("zero_done", done_cnt - d, 1);
    cap.delete();
    maxhold = 20;
    rx(8'h78);
    repeat (6) @(negedge clk);
    chk("x_ign", cap.size(), 0);
    chk("x_busy", bus.busy, 0);
    d = done_cnt;
    rx(8'h73);
    wait_bytes("mid_to", 10);
    rx(8'h73);
    rx(8'h70);
    wait_done("mid_done_to", d);
    repeat (30) @(negedge clk);
    chk("mid_done", done_cnt - d, 1);
    chk_dump("mid", 0, NB);
    d = done_cnt;
    rx(8'h70); rx(8'h00); rx(8'h3E); rx(8'h00); rx(8'h44);
    wait_done("over_to", d);
    chk_dump("over", 62, 68);
    rx(8'h73);
    wait_bytes("rst_mid_to", 20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_en", bus.uart_tx_enable, 0);
    chk("rst_mid_busy", bus.busy, 0);
    cap.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_dummy_n", cap.size(), 1);
    chk("rst_dummy_v", cap_at(0), 0);
    chk("rst_idle", bus.busy, 0);
    cap.delete();
    d = done_cnt;
    rx(8'h70); rx(8'h00); rx(8'h01); rx(8'h00); rx(8'h01);
    wait_done("one_to", d);
    chk("one_n", cap.size(), 2);
    chk("one_b", cap_at(0), 8'hA5);
    chk("one_x", cap_at(1), 8'hA5);
    chk("tx_stable", viol_stab, 0);
    chk("tx_en_ready", viol_en, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
